conv_seq_ctrl: RTL
==================

Name: conv_seq_ctrl

Overview:
- On-chip sequencer that drives the core's instruction and activation/weight SRAM port. It replaces bench-driven sequencing.
- For each kernel offset kij (0..K*K-1) it runs five steps in order:
  - stream weights from xmem to L0;
  - load L0 into the PE array;
  - stream the kij-shifted activation window from xmem to L0;
  - execute;
  - drain.
- Sits between the host/top-level controller (start/done) and core's inst/xmem inputs.
- Activations (addr 0..M*M-1) and the weights for the current kij (addr WGT_BASE..WGT_BASE+col-1) are preloaded by the host before each kij's weight phase. The host changes the weights between kijs, using kij_o to know which set is needed.

Parameters:
- M, 6, input feature map side.
- K, 3, kernel side.
- COL, 8, PE columns = weight words per kij.
- LEN_NIJ, 16, output pixels per kij; must equal (M-K+1)^2.
- ADDR_W, 11, xmem address width.
- WGT_BASE, 1024, xmem base address of weight words.
- GAP, 5, idle cycles after each L0 fill.
- LD_DRAIN, 20, idle cycles after PE load.
- EX_DRAIN, 100, idle cycles after execute.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a full K*K pass; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the pass completes.
- kij_o  out  4  current kernel offset index.
- inst  out  7  bit map: [0] load, [1] execute, [2] l0_wr, [3] l0_rd, [4] final_mem_read, [5] rchip, [6] mem_write.
- cen_act_wgt  out  1  xmem chip enable, active low.
- wen_act_wgt  out  1  xmem write enable, active low; tied 1 (read-only master).
- addr_act_wgt  out  ADDR_W  xmem address.

Behaviour:
- Output registration and reset:
  - All outputs are registered.
  - Reset forces state=IDLE, inst=0, cen=1, wen=1, addr=0, kij_o=0, busy=0, done=0, and all counters to 0.
  - Reset asserted mid-pass aborts immediately. There is no resume; a new start is required.
- States: IDLE, W_L0, W_GAP, LOAD, LD_WAIT, A_L0, A_GAP, EXEC, EX_WAIT, NEXT.
- IDLE: start=1 goes to W_L0 with kij=0. start in any other state is ignored.
- W_L0 (COL+1 cycles):
  - Cycles 0..COL-1: cen=0, addr=WGT_BASE+t.
  - l0_wr=1 in cycles 1..COL, i.e. one cycle behind each address, matching SRAM read latency of 1.
  - Cycle COL: cen=1, addr=0.
- W_GAP (GAP cycles): all strobes 0.
- LOAD (COL cycles): l0_rd=1 and load=1.
- LD_WAIT (LD_DRAIN cycles): all strobes 0.
- A_L0 (LEN_NIJ+1 cycles):
  - Cycle t<LEN_NIJ: cen=0, addr=(ki+oy)*M+(kj+ox), where ki=kij/K, kj=kij%K, oy=t/(M-K+1), ox=t%(M-K+1).
  - ox is the inner loop.
  - l0_wr is delayed one cycle, as in W_L0.
- A_GAP (GAP cycles): all strobes 0.
- EXEC (LEN_NIJ cycles): l0_rd=1 and execute=1.
- EX_WAIT (EX_DRAIN cycles): all strobes 0.
- NEXT (1 cycle):
  - If kij==K*K-1: done=1, busy=0, go to IDLE.
  - Otherwise: kij++ and go to W_L0.
- Cycles per kij: (COL+1)+GAP+COL+LD_DRAIN+(LEN_NIJ+1)+GAP+LEN_NIJ+EX_DRAIN+1. With defaults this is 181.
- rchip (inst[5]) = kij[0] throughout each kij, including its gaps.
- final_mem_read and mem_write are held at 0.
- Address arithmetic:
  - Computed without multipliers via row-base accumulators: base += M on each oy wrap, ox offset incremented.
  - Result is always < M*M; ADDR_W-bit wraparound is never reached.

Decomposition:
- Package conv_seq_pkg holds:
  - inst bit index localparams (INST_LOAD=0 … INST_MEMW=6);
  - the state enum;
  - default M, K, COL, LEN_NIJ, WGT_BASE.
- Sub-module conv_win_addr_gen holds the ki/kj/oy/ox counters and the activation address.
  - Inputs: clear, step, kij.
  - Outputs: addr, last.

Test Plan:
- Reset mid-EXEC of kij=4 → next cycle inst=0, cen=1, addr=0, busy=0, kij_o=0. A fresh start restarts at kij=0.
- start pulse with defaults:
  - busy rises the next cycle.
  - done pulses exactly 9*181 cycles after the first W_L0 cycle.
  - Exactly 1 done pulse; busy then falls.
- kij=0, A_L0 → address sequence 0,1,2,3,6,7,8,9,12,13,14,15,18,19,20,21.
- kij=8 (ki=2, kj=2) → address sequence 14,15,16,17,20,…,35.
- W_L0 → addresses 1024..1031 on consecutive cycles with cen=0. l0_wr high on exactly the 8 cycles each one cycle later.
- Strobe counts per kij:
  - load=8, execute=16, l0_rd=24, l0_wr=24.
  - rchip toggles 0,1,0,… across kij.
  - start asserted while busy has no effect.

Source files
------------

// File: rtl/conv_seq_pkg.sv
// Shared definitions for the convolution sequencer: instruction bit map, FSM states and
// default geometry.
package conv_seq_pkg;

  localparam int unsigned INST_LOAD  = 0;
  localparam int unsigned INST_EXEC  = 1;
  localparam int unsigned INST_L0WR  = 2;
  localparam int unsigned INST_L0RD  = 3;
  localparam int unsigned INST_FMRD  = 4;
  localparam int unsigned INST_RCHIP = 5;
  localparam int unsigned INST_MEMW  = 6;

  localparam int unsigned DefM       = 6;
  localparam int unsigned DefK       = 3;
  localparam int unsigned DefCol     = 8;
  localparam int unsigned DefLenNij  = 16;
  localparam int unsigned DefWgtBase = 1024;

  typedef enum logic [3:0] {
    StIdle,
    StWL0,
    StWGap,
    StLoad,
    StLdWait,
    StAL0,
    StAGap,
    StExec,
    StExWait,
    StNext
  } state_e;

endpackage

// File: rtl/conv_win_addr_gen.sv
// Activation window address generator: walks the (M-K+1)^2 output pixels of one kernel
// offset, ox innermost, producing xmem addresses with adders only.
module conv_win_addr_gen
  import conv_seq_pkg::*;
#(
  parameter int unsigned M      = DefM,
  parameter int unsigned K      = DefK,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              step,
  input  logic [3:0]        kij,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int unsigned OW = M - K + 1;

  logic [ADDR_W-1:0] ox_q, ox_d;
  logic [ADDR_W-1:0] oy_q, oy_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] origin;

  // Window origin ki*M+kj, selected from constants folded at elaboration.
  always_comb begin
    origin = '0;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        if (32'(kij) == r * K + c) origin = ADDR_W'(r * M + c);
      end
    end
  end

  always_comb begin
    ox_d  = ox_q;
    oy_d  = oy_q;
    row_d = row_q;
    if (clear) begin
      ox_d  = '0;
      oy_d  = '0;
      row_d = '0;
    end else if (step) begin
      if (ox_q == ADDR_W'(OW - 1)) begin
        ox_d  = '0;
        oy_d  = oy_q + 1'b1;
        row_d = row_q + ADDR_W'(M);
      end else begin
        ox_d = ox_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ox_q  <= '0;
      oy_q  <= '0;
      row_q <= '0;
    end else begin
      ox_q  <= ox_d;
      oy_q  <= oy_d;
      row_q <= row_d;
    end
  end

  assign addr = origin + row_q + ox_q;
  assign last = (ox_q == ADDR_W'(OW - 1)) && (oy_q == ADDR_W'(OW - 1));

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: for each kernel offset streams weights, loads the PE array, streams
// the shifted activation window, executes and drains, driving core inst and xmem ports.
module conv_seq_ctrl
  import conv_seq_pkg::*;
#(
  parameter int unsigned M        = DefM,
  parameter int unsigned K        = DefK,
  parameter int unsigned COL      = DefCol,
  parameter int unsigned LEN_NIJ  = DefLenNij,
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned WGT_BASE = DefWgtBase,
  parameter int unsigned GAP      = 5,
  parameter int unsigned LD_DRAIN = 20,
  parameter int unsigned EX_DRAIN = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [3:0]        kij_o,
  output logic [6:0]        inst,
  output logic              cen_act_wgt,
  output logic              wen_act_wgt,
  output logic [ADDR_W-1:0] addr_act_wgt
);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d, last_cnt;
  logic [3:0]        kij_q, kij_d;
  logic [6:0]        inst_q, inst_d;
  logic              cen_q, cen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              win_issue, win_step, win_clear, win_last;
  logic [ADDR_W-1:0] win_addr;

  conv_win_addr_gen #(
    .M      (M),
    .K      (K),
    .ADDR_W (ADDR_W)
  ) u_win_addr_gen (
    .clk   (clk),
    .reset (reset),
    .clear (win_clear),
    .step  (win_step),
    .kij   (kij_q),
    .addr  (win_addr),
    .last  (win_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      kij_q   <= '0;
      inst_q  <= '0;
      cen_q   <= 1'b1;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kij_q   <= kij_d;
      inst_q  <= inst_d;
      cen_q   <= cen_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    kij_d    = kij_q;
    last_cnt = '0;
    case (state_q)
      StWL0:    last_cnt = 16'(COL);
      StWGap:   last_cnt = 16'(GAP - 1);
      StLoad:   last_cnt = 16'(COL - 1);
      StLdWait: last_cnt = 16'(LD_DRAIN - 1);
      StAL0:    last_cnt = 16'(LEN_NIJ);
      StAGap:   last_cnt = 16'(GAP - 1);
      StExec:   last_cnt = 16'(LEN_NIJ - 1);
      StExWait: last_cnt = 16'(EX_DRAIN - 1);
      default:  last_cnt = '0;
    endcase

    if (state_q == StIdle) begin
      if (start) begin
        state_d = StWL0;
        cnt_d   = '0;
        kij_d   = '0;
      end
    end else if (cnt_q == last_cnt) begin
      cnt_d = '0;
      case (state_q)
        StWL0:    state_d = StWGap;
        StWGap:   state_d = StLoad;
        StLoad:   state_d = StLdWait;
        StLdWait: state_d = StAL0;
        StAL0:    state_d = StAGap;
        StAGap:   state_d = StExec;
        StExec:   state_d = StExWait;
        StExWait: state_d = StNext;
        StNext: begin
          if (kij_q == 4'(K * K - 1)) begin
            state_d = StIdle;
          end else begin
            kij_d   = kij_q + 4'd1;
            state_d = StWL0;
          end
        end
        default:  state_d = StIdle;
      endcase
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Outputs decode the next state so the registered values line up with state_q.
  always_comb begin
    inst_d    = '0;
    cen_d     = 1'b1;
    addr_d    = '0;
    busy_d    = (state_d != StIdle);
    done_d    = (state_q == StNext) && (state_d == StIdle);
    win_issue = 1'b0;
    if (state_d != StIdle) inst_d[INST_RCHIP] = kij_d[0];
    case (state_d)
      StWL0: begin
        if (cnt_d < 16'(COL)) begin
          cen_d  = 1'b0;
          addr_d = ADDR_W'(WGT_BASE) + ADDR_W'(cnt_d);
        end
        inst_d[INST_L0WR] = (cnt_d != '0);
      end
      StLoad: begin
        inst_d[INST_L0RD] = 1'b1;
        inst_d[INST_LOAD] = 1'b1;
      end
      StAL0: begin
        if (cnt_d < 16'(LEN_NIJ)) begin
          cen_d     = 1'b0;
          addr_d    = win_addr;
          win_issue = 1'b1;
        end
        inst_d[INST_L0WR] = (cnt_d != '0);
      end
      StExec: begin
        inst_d[INST_L0RD] = 1'b1;
        inst_d[INST_EXEC] = 1'b1;
      end
      default: ;
    endcase
  end

  // The generator parks on the final pixel rather than running past the window.
  assign win_step  = win_issue && !win_last;
  assign win_clear = (state_d != StAL0);

  assign busy         = busy_q;
  assign done         = done_q;
  assign kij_o        = kij_q;
  assign inst         = inst_q;
  assign cen_act_wgt  = cen_q;
  assign wen_act_wgt  = 1'b1;
  assign addr_act_wgt = addr_q;

endmodule
